fp_div: RTL and testbench

Sequential signed fixed-point divider for the datapath's Q(WIDTH-FBITS).FBITS arithmetic; default is Q8.24 (two's complement, 32 bits). It computes q = x / y, truncated toward zero, with a restoring shift-subtract algorithm at one quotient bit per clock. A start/busy/valid handshake frames each operation, and it flags divide-by-zero and overflow.

---
 rtl/fp_div.sv | 160 ++++++++++++++++
 tb/tb_fp_div.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fp_div.sv
// Sequential signed fixed-point divider, restoring shift-subtract, one quotient bit per clock.
// q = x / y truncated toward zero in Q(WIDTH-FBITS).FBITS, with divide-by-zero and overflow flags.
module fp_div #(
  parameter int WIDTH = 32,
  parameter int FBITS = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             valid,
  output logic             dbz,
  output logic             ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int NW = WIDTH + FBITS;
  localparam int CW = $clog2(NW + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(NW - 1);
  localparam logic [NW-1:0] QMAX_POS  = {{FBITS{1'b0}}, 1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [NW-1:0] QMAX_NEG  = {{FBITS{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_ay;
  logic [WIDTH-1:0] r_acc;
  logic [NW-1:0]    r_num;
  logic [NW-1:0]    r_quo;
  logic             r_neg_q;
  logic             r_neg_x;
  logic             r_valid;
  logic             r_dbz;
  logic             r_ovf;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic [WIDTH-1:0] w_ax;
  logic [WIDTH-1:0] w_ay;
  logic             w_y_zero;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic             w_ovf;

  // Magnitudes: the most negative word maps onto 2^(WIDTH-1) as unsigned.
  assign w_ax     = x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  assign w_ay     = y[WIDTH-1] ? (~y + {{(WIDTH-1){1'b0}}, 1'b1}) : y;
  assign w_y_zero = (y == {WIDTH{1'b0}});

  // A clear top bit in the difference means no borrow, i.e. trial >= divisor.
  assign w_trial  = {r_acc, r_num[NW-1]};
  assign w_diff   = w_trial - {1'b0, r_ay};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_ovf    = r_neg_q ? (r_quo > QMAX_NEG) : (r_quo > QMAX_POS);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (start && !w_y_zero) w_next = S_CALC;
        else                    w_next = S_IDLE;
      end
      S_CALC: begin
        if (r_cnt == LAST_STEP) w_next = S_DONE;
        else                    w_next = S_CALC;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_CALC:  w_busy = 1'b1;
      S_DONE:  w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Datapath: operand capture, one restoring step per CALC cycle, result formatting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= {CW{1'b0}};
      r_ay    <= {WIDTH{1'b0}};
      r_acc   <= {WIDTH{1'b0}};
      r_num   <= {NW{1'b0}};
      r_quo   <= {NW{1'b0}};
      r_neg_q <= 1'b0;
      r_neg_x <= 1'b0;
      r_valid <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
      r_q     <= {WIDTH{1'b0}};
      r_r     <= {WIDTH{1'b0}};
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dbz   <= w_y_zero;
            r_ovf   <= 1'b0;
            r_q     <= {WIDTH{1'b0}};
            r_r     <= {WIDTH{1'b0}};
            r_ay    <= w_ay;
            r_acc   <= {WIDTH{1'b0}};
            r_num   <= {w_ax, {FBITS{1'b0}}};
            r_quo   <= {NW{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_neg_q <= x[WIDTH-1] ^ y[WIDTH-1];
            r_neg_x <= x[WIDTH-1];
          end
        end
        S_CALC: begin
          r_acc <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_num <= {r_num[NW-2:0], 1'b0};
          r_quo <= {r_quo[NW-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        S_DONE: begin
          if (w_ovf) begin
            r_ovf <= 1'b1;
          end else begin
            r_valid <= 1'b1;
            r_q     <= r_neg_q ? (~r_quo[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : r_quo[WIDTH-1:0];
            r_r     <= r_neg_x ? (~r_acc + {{(WIDTH-1){1'b0}}, 1'b1}) : r_acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = w_busy;
  assign valid = r_valid;
  assign dbz   = r_dbz;
  assign ovf   = r_ovf;
  assign q     = r_q;
  assign r     = r_r;

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: driver pushes model results, negedge monitor pops and compares.
module tb_fp_div;
  localparam int WIDTH = 32;
  localparam int FBITS = 24;
  localparam int LAT   = WIDTH + FBITS + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             busy, valid, dbz, ovf;
  logic [WIDTH-1:0] q, r;

  fp_div #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy), .valid(valid), .dbz(dbz), .ovf(ovf), .q(q), .r(r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       flags;   // {valid, ovf, dbz}
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    int               lat;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  int   cyc    = 0;
  logic p_ovf  = 1'b0;
  logic p_dbz  = 1'b0;
  bit   last_zero = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer division of the scaled magnitudes, signs applied afterwards.
  task automatic model(input logic [WIDTH-1:0] xi, input logic [WIDTH-1:0] yi, output exp_t e);
    longint sx, sy, ax, ay, nq, nr, lim, qv, rv;
    bit neg;
    sx = longint'($signed(xi));
    sy = longint'($signed(yi));
    e.acc_cyc = 0;
    if (sy == 0) begin
      e.flags = 3'b001; e.q = '0; e.r = '0; e.lat = 0;
    end else begin
      ax  = (sx < 0) ? -sx : sx;
      ay  = (sy < 0) ? -sy : sy;
      nq  = (ax * (64'sd1 << FBITS)) / ay;
      nr  = (ax * (64'sd1 << FBITS)) % ay;
      neg = (sx < 0) != (sy < 0);
      lim = neg ? (64'sd1 << (WIDTH-1)) : ((64'sd1 << (WIDTH-1)) - 64'sd1);
      e.lat = LAT;
      if (nq > lim) begin
        e.flags = 3'b010; e.q = '0; e.r = '0;
      end else begin
        qv = neg ? -nq : nq;
        rv = (sx < 0) ? -nr : nr;
        e.flags = 3'b100; e.q = qv[WIDTH-1:0]; e.r = rv[WIDTH-1:0];
      end
    end
  endtask

  // Monitor: a completion is a valid pulse or a rising ovf/dbz.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (valid || (ovf && !p_ovf) || (dbz && !p_dbz))) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", {61'd0, valid, ovf, dbz}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("flags", {61'd0, valid, ovf, dbz}, {61'd0, e.flags});
        chk("q", {32'd0, q}, {32'd0, e.q});
        chk("r", {32'd0, r}, {32'd0, e.r});
        chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
        chk("busy_at_end", {63'd0, busy}, 64'd0);
      end
      n_done++;
    end
    p_ovf = ovf;
    p_dbz = dbz;
  end

  task automatic issue(input logic [WIDTH-1:0] xi, input logic [WIDTH-1:0] yi,
                       input int mid_start, input int rst_at);
    exp_t e;
    int   done0;
    bit   aborted;
    aborted = 1'b0;
    model(xi, yi, e);
    @(negedge clk);
    x = xi; y = yi; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.acc_cyc = cyc;
    done0 = n_done;
    sb.push_back(e);
    x = $urandom; y = $urandom;
    last_zero = (yi == '0);
    for (int k = 1; k <= LAT + 20 && n_done == done0; k++) begin
      @(negedge clk);
      if (k == mid_start) begin
        x = 32'h7FFF_FFFF; y = 32'h0000_0001; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_ignored_start", {63'd0, busy}, 64'd1);
      end
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_busy",  {63'd0, busy},  64'd0);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_q", {32'd0, q}, 64'd0);
        chk("rst_r", {32'd0, r}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) chk("completion_timeout", 64'(n_done != done0), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] xv, yv;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",  {63'd0, busy},  64'd0);
    chk("reset_valid", {63'd0, valid}, 64'd0);
    chk("reset_flags", {62'd0, dbz, ovf}, 64'd0);
    chk("reset_q", {32'd0, q}, 64'd0);
    chk("reset_r", {32'd0, r}, 64'd0);
    rst = 1'b0;

    issue(32'h0080_0000, 32'h0008_0000, 20, 0);  // 0.5 / 0.03125, with an ignored start
    chk("case1_q_hold", {32'd0, q}, 64'h1000_0000);
    issue(32'hFF00_0000, 32'h0040_0000, 0, 0);
    chk("case2_q_hold", {32'd0, q}, 64'hFC00_0000);
    issue(32'h0100_0000, 32'h0300_0000, 0, 0);
    chk("case3_q_hold", {32'd0, q}, 64'h0055_5555);
    chk("case3_r_hold", {32'd0, r}, 64'h0100_0000);
    issue(32'h1234_5678, 32'h0000_0000, 0, 0);
    repeat (3) @(negedge clk);
    chk("dbz_held", {62'd0, dbz, busy}, 64'd2);
    issue(32'h6400_0000, 32'h0080_0000, 0, 0);   // overflow, also clears dbz
    chk("ovf_dbz_cleared", {63'd0, dbz}, 64'd0);
    issue(32'h8000_0000, 32'h8000_0000, 0, 0);
    issue(32'h8000_0000, 32'h0100_0000, 0, 0);
    issue(32'h8000_0000, 32'hFF00_0000, 0, 0);
    issue(32'h0000_0000, 32'hFFFF_FFFF, 0, 0);
    issue(32'h0080_0000, 32'h0008_0000, 0, 30);  // aborted by reset
    issue(32'h0080_0000, 32'h0008_0000, 0, 0);

    for (int i = 0; i < 40; i++) begin
      xv = $urandom >> $urandom_range(0, 31);
      yv = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) xv = ~xv + 32'd1;
      if ($urandom_range(0, 1) == 1) yv = ~yv + 32'd1;
      if ($urandom_range(0, 9) == 0) yv = '0;
      if (last_zero && yv == '0) yv = 32'h0000_0001;
      issue(xv, yv, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
